// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and defaults for the MEM-stage memory sequencer
package mem_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts BUSY cycles and flags the last one before an abort
module mem_wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign expired_o = cnt_q == LAST;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: stalls the pipeline around a req/ack data-memory access with timeout abort
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              mem_ack,
  input  logic              mem_err,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              StallM,
  output logic              FlushW,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              mem_fault,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_t            state_q;
  logic              req_q, we_q, fault_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              access, busy, expired;
  assign access = MemtoRegM | MemWriteM;
  assign busy   = state_q == ST_BUSY;
  assign StallM = (state_q == ST_IDLE && access) || busy;
  assign FlushW = StallM;
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (!busy),
    .enable_i (busy),
    .expired_o(expired)
  );
  // DONE always falls back to IDLE, so a still-asserted access is not re-issued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (StallM && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: if (access) begin
          state_q <= ST_BUSY;
          req_q   <= 1'b1;
          we_q    <= MemWriteM;
          addr_q  <= ALUOutM;
          wdata_q <= WriteDataM;
        end
        ST_BUSY: if (mem_ack) begin
          state_q <= ST_DONE;
          req_q   <= 1'b0;
          if (!we_q) rdata_q <= mem_rdata;
          if (mem_err) fault_q <= 1'b1;
        end else if (expired) begin
          state_q <= ST_DONE;
          req_q   <= 1'b0;
          rdata_q <= '0;
          fault_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;
  assign mem_fault = fault_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: vector table, directed corner sequences and random traffic against a reference model
module tb_mem_stage_ctrl;
  localparam int TO = 8;
  localparam int CMAX = 15;
  logic        clk = 1'b0;
  logic        rst_n, MemtoRegM, MemWriteM, mem_ack, mem_err;
  logic [31:0] ALUOutM, WriteDataM, mem_rdata;
  logic        mem_req, mem_we, StallM, FlushW, mem_fault;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;
  logic [3:0]  stall_cnt;
  int checks = 0, errors = 0;
  int req_cycles, req_rises, stall_cycles;
  logic prev_req;
  // reference: one outstanding access, its age in BUSY cycles, and a one-cycle release flag
  bit m_busy, m_done, m_we, m_fault;
  int m_age, m_cnt;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(32), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .mem_ack(mem_ack), .mem_err(mem_err),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .StallM(StallM), .FlushW(FlushW), .ReadDataM(ReadDataM),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic rst, rd, wr; logic [31:0] addr, wdata; logic ack, err; logic [31:0] rdata;
    logic e_stall, e_req, e_we; logic [31:0] e_addr, e_wdata, e_rdata; logic e_fault; logic [3:0] e_cnt;
  } vec_t;
  vec_t tbl[9];

  function automatic bit m_stall();
    return m_busy || (!m_done && (MemtoRegM || MemWriteM));
  endfunction

  task automatic expect_eq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    bit s = m_stall();
    checks++;
    if (StallM !== s || FlushW !== s || mem_req !== m_busy || mem_we !== m_we || mem_addr !== m_addr ||
        mem_wdata !== m_wdata || ReadDataM !== m_rdata || mem_fault !== m_fault || stall_cnt !== 4'(m_cnt)) begin
      errors++;
      $display("FAIL %s @%0t: got stall=%b flush=%b req=%b we=%b addr=%h wdata=%h rdata=%h fault=%b cnt=%0d expected stall=%b req=%b we=%b addr=%h wdata=%h rdata=%h fault=%b cnt=%0d",
               tag, $time, StallM, FlushW, mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, mem_fault, stall_cnt,
               s, m_busy, m_we, m_addr, m_wdata, m_rdata, m_fault, m_cnt);
    end
  endtask

  task automatic model_step();
    bit s = m_stall();
    if (!rst_n) begin
      {m_busy, m_done, m_we, m_fault} = '0;
      m_age = 0; m_cnt = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    end else begin
      if (s && m_cnt < CMAX) m_cnt++;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0; m_done = 1;
          if (!m_we) m_rdata = mem_rdata;
          if (mem_err) m_fault = 1;
        end else if (m_age + 1 == TO) begin
          m_busy = 0; m_done = 1; m_rdata = 0; m_fault = 1;
        end else m_age++;
      end else if (m_done) m_done = 0;
      else if (MemtoRegM || MemWriteM) begin
        m_busy = 1; m_age = 0; m_we = MemWriteM; m_addr = ALUOutM; m_wdata = WriteDataM;
      end
    end
  endtask

  task automatic drive(input logic r, rd, wr, input logic [31:0] a, wd,
                       input logic ack, err, input logic [31:0] rdat, input string tag);
    rst_n = r; MemtoRegM = rd; MemWriteM = wr; ALUOutM = a; WriteDataM = wd;
    mem_ack = ack; mem_err = err; mem_rdata = rdat;
    #1;
    check_model(tag);
    if (mem_req) req_cycles++;
    if (mem_req && !prev_req) req_rises++;
    if (StallM) stall_cycles++;
    prev_req = mem_req;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_stats();
    req_cycles = 0; req_rises = 0; stall_cycles = 0; prev_req = mem_req;
  endtask

  initial begin
    rst_n = 0; MemtoRegM = 0; MemWriteM = 0; ALUOutM = 0; WriteDataM = 0;
    mem_ack = 0; mem_err = 0; mem_rdata = 0;
    {m_busy, m_done, m_we, m_fault} = '0;
    m_age = 0; m_cnt = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    repeat (2) @(negedge clk);
    tbl[0] = '{1,0,0,32'h0,  32'h0, 0,0,32'h0,      0,0,0,32'h0,  32'h0, 32'h0,        0,4'd0};
    tbl[1] = '{1,1,0,32'h100,32'h0, 0,0,32'h0,      1,0,0,32'h0,  32'h0, 32'h0,        0,4'd0};
    tbl[2] = '{1,1,0,32'h100,32'h0, 1,0,32'hDEADBEEF,1,1,0,32'h100,32'h0, 32'h0,        0,4'd1};
    tbl[3] = '{1,1,0,32'h100,32'h0, 0,0,32'h0,      0,0,0,32'h100,32'h0, 32'hDEADBEEF, 0,4'd2};
    tbl[4] = '{1,0,0,32'h0,  32'h0, 1,1,32'hFFFF,   0,0,0,32'h100,32'h0, 32'hDEADBEEF, 0,4'd2};
    tbl[5] = '{1,0,1,32'h200,32'h55,0,0,32'h0,      1,0,0,32'h100,32'h0, 32'hDEADBEEF, 0,4'd2};
    tbl[6] = '{1,0,1,32'h200,32'h55,0,0,32'h0,      1,1,1,32'h200,32'h55,32'hDEADBEEF, 0,4'd3};
    tbl[7] = '{0,0,1,32'h200,32'h55,0,0,32'h0,      1,1,1,32'h200,32'h55,32'hDEADBEEF, 0,4'd4};
    tbl[8] = '{1,0,0,32'h0,  32'h0, 0,0,32'h0,      0,0,0,32'h0,  32'h0, 32'h0,        0,4'd0};
    for (int i = 0; i < 9; i++) begin
      rst_n = tbl[i].rst; MemtoRegM = tbl[i].rd; MemWriteM = tbl[i].wr; ALUOutM = tbl[i].addr;
      WriteDataM = tbl[i].wdata; mem_ack = tbl[i].ack; mem_err = tbl[i].err; mem_rdata = tbl[i].rdata;
      #1;
      checks++;
      if (StallM !== tbl[i].e_stall || FlushW !== tbl[i].e_stall || mem_req !== tbl[i].e_req ||
          mem_we !== tbl[i].e_we || mem_addr !== tbl[i].e_addr || mem_wdata !== tbl[i].e_wdata ||
          ReadDataM !== tbl[i].e_rdata || mem_fault !== tbl[i].e_fault || stall_cnt !== tbl[i].e_cnt) begin
        errors++;
        $display("FAIL vec%0d: got stall=%b req=%b we=%b addr=%h wdata=%h rdata=%h fault=%b cnt=%0d expected stall=%b req=%b we=%b addr=%h wdata=%h rdata=%h fault=%b cnt=%0d",
                 i, StallM, mem_req, mem_we, mem_addr, mem_wdata, ReadDataM, mem_fault, stall_cnt,
                 tbl[i].e_stall, tbl[i].e_req, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata,
                 tbl[i].e_rdata, tbl[i].e_fault, tbl[i].e_cnt);
      end
      @(posedge clk);
      @(negedge clk);
    end

    drive(0,0,0,0,0,0,0,0,"rst");
    clear_stats();
    drive(1,0,1,32'h200,32'h12345678,0,0,0,"st_idle");
    drive(1,0,1,32'hABC,32'h0,0,0,0,"st_w1");
    drive(1,1,0,32'hABC,32'h0,0,0,0,"st_w2");
    drive(1,0,1,32'hABC,32'h0,0,0,0,"st_w3");
    expect_eq("st_wdata", mem_wdata, 32'h12345678);
    expect_eq("st_addr", mem_addr, 32'h200);
    expect_eq("st_we", {31'h0, mem_we}, 32'h1);
    drive(1,0,1,32'h200,32'h12345678,1,0,0,"st_ack");
    drive(1,0,1,32'h200,32'h12345678,0,0,0,"st_done");
    expect_eq("st_stall_cycles", stall_cycles, 5);

    clear_stats();
    drive(1,1,0,32'h300,0,0,0,0,"b2b_a_idle");
    drive(1,1,0,32'h300,0,1,0,32'hAAAA0001,"b2b_a_busy");
    drive(1,1,0,32'h300,0,0,0,0,"b2b_a_done");
    drive(1,1,0,32'h304,0,0,0,0,"b2b_b_idle");
    drive(1,1,0,32'h304,0,1,0,32'hBBBB0002,"b2b_b_busy");
    drive(1,1,0,32'h304,0,0,0,0,"b2b_b_done");
    drive(1,0,0,0,0,0,0,0,"b2b_end");
    expect_eq("b2b_req_rises", req_rises, 2);
    expect_eq("b2b_req_cycles", req_cycles, 2);
    expect_eq("b2b_rdata", ReadDataM, 32'hBBBB0002);

    clear_stats();
    drive(1,1,0,32'h400,0,0,0,0,"to_idle");
    for (int i = 0; i < TO; i++) drive(1,1,0,32'h400,0,0,0,32'h77,"to_busy");
    expect_eq("to_req_cycles", req_cycles, TO);
    expect_eq("to_req_dropped", {31'h0, mem_req}, 32'h0);
    drive(1,1,0,32'h400,0,0,0,0,"to_done");
    repeat (3) drive(1,0,0,0,0,0,0,0,"to_after");
    expect_eq("to_fault_sticky", {31'h0, mem_fault}, 32'h1);
    expect_eq("to_rdata_zero", ReadDataM, 32'h0);

    drive(0,0,0,0,0,0,0,0,"rst2");
    drive(1,1,0,32'h500,0,0,0,0,"err_idle");
    drive(1,1,0,32'h500,0,1,1,32'hC0FFEE00,"err_ack");
    expect_eq("err_fault", {31'h0, mem_fault}, 32'h1);
    expect_eq("err_rdata", ReadDataM, 32'hC0FFEE00);
    drive(1,1,0,32'h500,0,0,0,0,"err_done");
    drive(0,0,0,0,0,0,0,0,"rst3");
    drive(1,1,0,32'h600,0,0,0,0,"race_idle");
    for (int i = 0; i < TO - 1; i++) drive(1,1,0,32'h600,0,0,1,0,"race_busy");
    drive(1,1,0,32'h600,0,1,0,32'h600DF00D,"race_ack");
    expect_eq("race_rdata", ReadDataM, 32'h600DF00D);
    expect_eq("race_no_fault", {31'h0, mem_fault}, 32'h0);
    drive(1,0,0,0,0,0,0,0,"race_done");

    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0,199) != 0, $urandom_range(0,2) == 0, $urandom_range(0,3) == 0,
            $urandom, $urandom, $urandom_range(0,3) == 0, $urandom_range(0,3) == 0, $urandom, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
